// File: rtl/dec_bp_pkg.sv
// Shared types and the round-robin pick helper for the BP/BPV size-decode schedulers.
package dec_bp_pkg;

    localparam int unsigned SUFFIX_W_DEF = 128;
    localparam int unsigned SIZE_W_DEF   = 8;
    localparam int unsigned MAX_REQ      = 8;
    localparam int unsigned ID_W         = 3;
    localparam int unsigned IDX_W        = ID_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } sched_state_e;

    typedef struct packed {
        logic [MAX_REQ-1:0] onehot;
        logic [ID_W-1:0]    id;
        logic               any;
    } rr_pick_t;

    // First requester at or after ptr, wrapping at num (which need not be a power of two).
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                         input logic [ID_W-1:0]    ptr,
                                         input int unsigned        num);
        rr_pick_t         r;
        logic [IDX_W-1:0] idx;
        r = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            idx = {1'b0, ptr} + IDX_W'(k);
            if (idx >= IDX_W'(num)) begin
                idx = idx - IDX_W'(num);
            end
            if ((k < num) && !r.any && req[idx[ID_W-1:0]]) begin
                r.any                    = 1'b1;
                r.id                     = idx[ID_W-1:0];
                r.onehot[idx[ID_W-1:0]]  = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dec_rr_arb.sv
// Combinational round-robin picker shared by the SSM schedulers.
module dec_rr_arb
    import dec_bp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt_onehot,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       any
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    rr_pick_t pick;
    logic     pick_unused;

    always_comb begin
        pick       = rr_pick(MAX_REQ'(req), ID_W'(ptr), NUM_REQ);
        gnt_onehot = pick.onehot[NUM_REQ-1:0];
        gnt_id     = pick.id[PTR_W-1:0];
        any        = pick.any;
    end

    // Upper pick bits are only meaningful for larger requester counts.
    assign pick_unused = ^pick;

endmodule

// File: rtl/dec_bp_size_sched.sv
// Shares one BP/BPV size-decode unit between NUM_REQ SSM parsers: arbitrate, issue,
// wait out the unit latency, and hand the (saturated) size back to the owner.
module dec_bp_size_sched
    import dec_bp_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SUFFIX_W = SUFFIX_W_DEF,
    parameter int unsigned SIZE_W   = SIZE_W_DEF,
    parameter int unsigned SZ_LAT   = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*SUFFIX_W-1:0]  req_suffix,
    input  logic [NUM_REQ-1:0]           req_mode_bp,
    input  logic [NUM_REQ-1:0]           req_use2x2,
    output logic [NUM_REQ-1:0]           grant,
    output logic                         sz_issue,
    output logic [SUFFIX_W-1:0]          sz_suffix,
    output logic                         sz_mode_bp,
    output logic                         sz_use2x2,
    input  logic [SIZE_W-1:0]            sz_size,
    output logic [NUM_REQ-1:0]           rsp_valid,
    output logic [SIZE_W-1:0]            rsp_size,
    input  logic [NUM_REQ-1:0]           rsp_ready,
    output logic                         busy,
    output logic                         err_oversize
);

    localparam int unsigned PTR_W     = $clog2(NUM_REQ);
    localparam int unsigned LAT_W     = (SZ_LAT > 1) ? $clog2(SZ_LAT) : 1;
    localparam int unsigned SFX_CNT_W = $clog2(SUFFIX_W + 1);
    localparam int unsigned CMP_W     = (SIZE_W > SFX_CNT_W) ? SIZE_W : SFX_CNT_W;

    sched_state_e         state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     owner;
    logic [LAT_W-1:0]     lat_cnt;
    logic [NUM_REQ-1:0]   arb_onehot;
    logic [PTR_W-1:0]     arb_id;
    logic                 arb_any;
    logic [PTR_W-1:0]     next_ptr;
    logic [SUFFIX_W-1:0]  win_suffix;
    logic                 hs;
    logic                 take;
    logic                 fin;
    logic                 oversize;

    dec_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
        .req        (req),
        .ptr        (rr_ptr),
        .gnt_onehot (arb_onehot),
        .gnt_id     (arb_id),
        .any        (arb_any)
    );

    // Grant decision, winner operand mux and result-capture qualifiers.
    always_comb begin
        hs       = (state == ST_RESP) && rsp_ready[owner];
        take     = rst_n && arb_any && ((state == ST_IDLE) || hs);
        grant    = take ? arb_onehot : '0;
        next_ptr = (arb_id == PTR_W'(NUM_REQ - 1)) ? '0 : arb_id + PTR_W'(1);
        fin      = ((state == ST_ISSUE) && (SZ_LAT == 1)) ||
                   ((state == ST_WAIT) && (lat_cnt == LAT_W'(1)));
        oversize = CMP_W'(sz_size) > CMP_W'(SUFFIX_W);
        win_suffix = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_id == PTR_W'(i)) begin
                win_suffix = req_suffix[i*SUFFIX_W +: SUFFIX_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            lat_cnt      <= '0;
            sz_issue     <= 1'b0;
            sz_suffix    <= '0;
            sz_mode_bp   <= 1'b0;
            sz_use2x2    <= 1'b0;
            rsp_valid    <= '0;
            rsp_size     <= '0;
            busy         <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            sz_issue <= 1'b0;
            if (take) begin
                sz_issue   <= 1'b1;
                sz_suffix  <= win_suffix;
                sz_mode_bp <= req_mode_bp[arb_id];
                sz_use2x2  <= req_use2x2[arb_id];
                owner      <= arb_id;
                rr_ptr     <= next_ptr;
            end
            // Result is sampled on the edge that enters RESP.
            if (fin) begin
                rsp_valid <= NUM_REQ'(1) << owner;
                rsp_size  <= oversize ? SIZE_W'(SUFFIX_W) : sz_size;
                if (oversize) begin
                    err_oversize <= 1'b1;
                end
            end
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        state <= ST_ISSUE;
                        busy  <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    lat_cnt <= LAT_W'(SZ_LAT - 1);
                    state   <= (SZ_LAT == 1) ? ST_RESP : ST_WAIT;
                end
                ST_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                    if (fin) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (hs) begin
                        rsp_valid <= '0;
                        if (take) begin
                            state <= ST_ISSUE;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
